// File: rtl/fifo_level_pkg.sv
// Shared definitions for the fifo_level block: read-mode constants and the
// per-cycle operation encoding used by the pointer/count next-state logic.
package fifo_level_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Accepted operation in a cycle, bit 1 = read accepted, bit 0 = write accepted
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    // Classify the accepted read/write pair of a cycle
    function automatic fifo_op_e fifo_op(input logic wr_acc, input logic rd_acc);
        fifo_op_e op;
        case ({rd_acc, wr_acc})
            2'b01:   op = OP_WR;
            2'b10:   op = OP_RD;
            2'b11:   op = OP_RW;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fifo_level_reg_file.sv
// B x 2**W storage array: synchronous write port, asynchronous read port.
// A read of the slot being written in the same cycle returns the old word,
// because the write only lands at the clock edge.
module reg_file #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_we,
    input  logic [W-1:0] i_waddr,
    input  logic [B-1:0] i_wdata,
    input  logic [W-1:0] i_raddr,
    output logic [B-1:0] o_rdata
);

    logic [B-1:0] r_mem [0:(2**W)-1];

    // Write port: store the incoming word on an enabled edge; contents are never reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_level.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush, and a choice of
// registered or first-word-fall-through read data.
module fifo_level
    import fifo_level_pkg::*;
#(
    parameter int B     = 8,
    parameter int W     = 4,
    parameter int AF_TH = (2**W) - 2,
    parameter int AE_TH = 2,
    parameter int FWFT  = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam int         D        = 2**W;
    localparam logic [W-1:0] PTR_ZERO = {W{1'b0}};
    localparam logic [W-1:0] PTR_ONE  = W'(1);
    localparam logic [W:0]   CNT_ZERO = {(W+1){1'b0}};
    localparam logic [W:0]   CNT_ONE  = (W+1)'(1);
    localparam logic [W:0]   CNT_FULL = (W+1)'(D);
    localparam logic [W:0]   AF_LVL   = (W+1)'(AF_TH);
    localparam logic [W:0]   AE_LVL   = (W+1)'(AE_TH);

    // Registered state
    logic [W-1:0] r_wr_ptr;
    logic [W-1:0] r_rd_ptr;
    logic [W:0]   r_count;
    logic         r_empty;
    logic         r_full;
    logic         r_almost_empty;
    logic         r_almost_full;
    logic         r_overflow;
    logic         r_underflow;
    logic [B-1:0] r_rdata;

    // Next-state and decode wires
    logic         w_rd_acc;
    logic         w_wr_acc;
    logic         w_we;
    fifo_op_e     w_op;
    logic [W-1:0] w_wr_ptr_nx;
    logic [W-1:0] w_rd_ptr_nx;
    logic [W:0]   w_count_nx;
    logic         w_empty_nx;
    logic         w_full_nx;
    logic         w_almost_empty_nx;
    logic         w_almost_full_nx;
    logic         w_overflow_nx;
    logic         w_underflow_nx;
    logic [B-1:0] w_head;

    // Acceptance, pointer/count next state, error flags and status decode
    always_comb begin
        // A read only succeeds with data present; a write at full succeeds
        // only because a simultaneous read frees the slot.
        w_rd_acc          = rd & ~r_empty;
        w_wr_acc          = wr & (~r_full | rd);
        w_op              = fifo_op(w_wr_acc, w_rd_acc);
        w_wr_ptr_nx       = r_wr_ptr;
        w_rd_ptr_nx       = r_rd_ptr;
        w_count_nx        = r_count;
        w_overflow_nx     = r_overflow;
        w_underflow_nx    = r_underflow;
        if (clr) begin
            // Flush discards everything and ignores rd/wr this cycle
            w_wr_ptr_nx    = PTR_ZERO;
            w_rd_ptr_nx    = PTR_ZERO;
            w_count_nx     = CNT_ZERO;
            w_overflow_nx  = 1'b0;
            w_underflow_nx = 1'b0;
        end else begin
            w_overflow_nx  = r_overflow  | (wr & ~w_wr_acc);
            w_underflow_nx = r_underflow | (rd & ~w_rd_acc);
            case (w_op)
                OP_WR: begin
                    w_wr_ptr_nx = r_wr_ptr + PTR_ONE;
                    w_count_nx  = r_count + CNT_ONE;
                end
                OP_RD: begin
                    w_rd_ptr_nx = r_rd_ptr + PTR_ONE;
                    w_count_nx  = r_count - CNT_ONE;
                end
                OP_RW: begin
                    w_wr_ptr_nx = r_wr_ptr + PTR_ONE;
                    w_rd_ptr_nx = r_rd_ptr + PTR_ONE;
                end
                default: begin
                    w_wr_ptr_nx = r_wr_ptr;
                    w_rd_ptr_nx = r_rd_ptr;
                end
            endcase
        end
        // Flags are decoded from the next count so they register alongside it
        w_empty_nx        = (w_count_nx == CNT_ZERO);
        w_full_nx         = (w_count_nx == CNT_FULL);
        w_almost_full_nx  = (w_count_nx >= AF_LVL);
        w_almost_empty_nx = (w_count_nx <= AE_LVL);
    end

    // Storage is written only by an accepted write outside flush and reset
    assign w_we = w_wr_acc & ~clr & reset_n;

    reg_file #(
        .B (B),
        .W (W)
    ) u_reg_file (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // Control state register: pointers, count, status and sticky error flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr       <= PTR_ZERO;
            r_rd_ptr       <= PTR_ZERO;
            r_count        <= CNT_ZERO;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b1;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nx;
            r_rd_ptr       <= w_rd_ptr_nx;
            r_count        <= w_count_nx;
            r_empty        <= w_empty_nx;
            r_full         <= w_full_nx;
            r_almost_empty <= w_almost_empty_nx;
            r_almost_full  <= w_almost_full_nx;
            r_overflow     <= w_overflow_nx;
            r_underflow    <= w_underflow_nx;
        end
    end

    // Registered read data: capture the head word on an accepted read, hold otherwise (flush keeps it)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdata <= {B{1'b0}};
        end else if (!clr && w_rd_acc) begin
            r_rdata <= w_head;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    // In fall-through mode the head word is presented directly from storage
    assign r_data       = (FWFT == FIFO_FWFT) ? w_head : r_rdata;
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_empty = r_almost_empty;
    assign almost_full  = r_almost_full;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: one registered-read and one fall-through instance
// share stimulus and are compared against a queue-based reference model.
module tb_fifo_level;

    logic       clk;
    logic       reset_n;
    logic       clr;
    logic       wr;
    logic       rd;
    logic [7:0] w_data;

    logic [7:0] s_rdata, f_rdata;
    logic [2:0] s_count, f_count;
    logic       s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
    logic       f_empty, f_full, f_ae, f_af, f_ovf, f_udf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_udf;
    logic [7:0] m_rs;

    fifo_level #(.B(8), .W(2), .AF_TH(3), .AE_TH(1), .FWFT(0)) u_std (
        .clk(clk), .reset_n(reset_n), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(s_rdata), .empty(s_empty), .full(s_full), .almost_empty(s_ae),
        .almost_full(s_af), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
    );

    fifo_level #(.B(8), .W(2), .AF_TH(3), .AE_TH(1), .FWFT(1)) u_fwft (
        .clk(clk), .reset_n(reset_n), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(f_rdata), .empty(f_empty), .full(f_full), .almost_empty(f_ae),
        .almost_full(f_af), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    always #5 clk = ~clk;

    // Model of one clock edge, derived from the acceptance rules
    task automatic model_update(input bit i_wr, input bit i_rd, input bit i_clr, input logic [7:0] i_d);
        int n;
        bit ra, wa;
        n = mq.size();
        if (!reset_n) begin
            mq.delete(); m_ovf = 0; m_udf = 0; m_rs = 8'h00;
        end else if (i_clr) begin
            mq.delete(); m_ovf = 0; m_udf = 0;
        end else begin
            ra = i_rd && (n > 0);
            wa = i_wr && ((n < 4) || i_rd);
            if (i_rd && !ra) m_udf = 1;
            if (i_wr && !wa) m_ovf = 1;
            if (ra) m_rs = mq.pop_front();
            if (wa) mq.push_back(i_d);
        end
    endtask

    // Expected {count, empty, full, almost_empty, almost_full, overflow, underflow}
    function automatic logic [8:0] exp_status();
        int n;
        n = mq.size();
        return {3'(n), n == 0, n == 4, n <= 1, n >= 3, m_ovf, m_udf};
    endfunction

    // Drive one cycle from a falling edge, clock it, return at the next falling edge
    task automatic step(input bit i_wr, input bit i_rd, input bit i_clr, input logic [7:0] i_d);
        wr = i_wr; rd = i_rd; clr = i_clr; w_data = i_d;
        @(posedge clk);
        model_update(i_wr, i_rd, i_clr, i_d);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(0, 0, 0, 8'h00);
        step(0, 0, 0, 8'h00);
        reset_n = 1'b1;
        n_checks++;
        if ({s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_udf} !== 9'b000_1_0_1_0_0_0) begin
            n_errors++; $display("FAIL reset_std_status got=%b exp=%b", {s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_udf}, 9'b000_1_0_1_0_0_0);
        end
        n_checks++;
        if ({f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_udf} !== 9'b000_1_0_1_0_0_0) begin
            n_errors++; $display("FAIL reset_fwft_status got=%b exp=%b", {f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_udf}, 9'b000_1_0_1_0_0_0);
        end
        n_checks++;
        if (s_rdata !== 8'h00) begin
            n_errors++; $display("FAIL reset_rdata got=%h exp=00", s_rdata);
        end
    endtask

    task automatic test_fill();
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 8'(8'h11 * (i + 1));
            step(1, 0, 0, v);
            n_checks++;
            if (s_count !== 3'(i + 1) || f_count !== 3'(i + 1)) begin
                n_errors++; $display("FAIL fill_count got=%0d/%0d exp=%0d", s_count, f_count, i + 1);
            end
            n_checks++;
            if ({s_ae, s_af, s_full} !== {(i + 1) <= 1, (i + 1) >= 3, (i + 1) == 4}) begin
                n_errors++; $display("FAIL fill_flags step=%0d got ae/af/full=%b%b%b", i, s_ae, s_af, s_full);
            end
            n_checks++;
            if (f_rdata !== 8'h11) begin
                n_errors++; $display("FAIL fill_fwft_head got=%h exp=11", f_rdata);
            end
        end
        step(1, 0, 0, 8'h99);
        n_checks++;
        if ({s_count, s_ovf, f_count, f_ovf} !== {3'd4, 1'b1, 3'd4, 1'b1}) begin
            n_errors++; $display("FAIL fill_overflow got cnt=%0d ovf=%b / cnt=%0d ovf=%b exp cnt=4 ovf=1", s_count, s_ovf, f_count, f_ovf);
        end
    endtask

    task automatic test_drain_wrap();
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 8'(8'h11 * (i + 1));
            n_checks++;
            if (f_rdata !== v) begin
                n_errors++; $display("FAIL drain_fwft_lead got=%h exp=%h", f_rdata, v);
            end
            step(0, 1, 0, 8'h00);
            n_checks++;
            if (s_rdata !== v) begin
                n_errors++; $display("FAIL drain_std_lag got=%h exp=%h", s_rdata, v);
            end
        end
        n_checks++;
        if (s_empty !== 1'b1 || f_empty !== 1'b1) begin
            n_errors++; $display("FAIL drain_empty got=%b/%b exp=1", s_empty, f_empty);
        end
        step(1, 0, 0, 8'h55);
        n_checks++;
        if (f_rdata !== 8'h55 || s_rdata !== 8'h44) begin
            n_errors++; $display("FAIL wrap_write got fwft=%h std=%h exp 55/44", f_rdata, s_rdata);
        end
        step(0, 1, 0, 8'h00);
        n_checks++;
        if (s_rdata !== 8'h55 || s_empty !== 1'b1) begin
            n_errors++; $display("FAIL wrap_read got=%h empty=%b exp 55/1", s_rdata, s_empty);
        end
    endtask

    task automatic test_simul_full();
        logic [7:0] exp_q[$];
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'hA1 + i));
        n_checks++;
        if (f_rdata !== 8'hA1 || s_full !== 1'b1) begin
            n_errors++; $display("FAIL full_pre got head=%h full=%b exp a1/1", f_rdata, s_full);
        end
        step(1, 1, 0, 8'h66);
        n_checks++;
        if ({s_count, s_ovf, f_count, f_ovf} !== {3'd4, 1'b0, 3'd4, 1'b0}) begin
            n_errors++; $display("FAIL full_rw_status got cnt=%0d ovf=%b / cnt=%0d ovf=%b exp 4/0", s_count, s_ovf, f_count, f_ovf);
        end
        n_checks++;
        if (s_rdata !== 8'hA1) begin
            n_errors++; $display("FAIL full_rw_oldest got=%h exp=a1", s_rdata);
        end
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
        foreach (exp_q[i]) begin
            n_checks++;
            if (f_rdata !== exp_q[i]) begin
                n_errors++; $display("FAIL full_drain_fwft got=%h exp=%h", f_rdata, exp_q[i]);
            end
            step(0, 1, 0, 8'h00);
            n_checks++;
            if (s_rdata !== exp_q[i]) begin
                n_errors++; $display("FAIL full_drain_std got=%h exp=%h", s_rdata, exp_q[i]);
            end
        end
    endtask

    task automatic test_simul_empty();
        step(1, 1, 0, 8'h77);
        n_checks++;
        if ({s_count, s_udf, f_count, f_udf} !== {3'd1, 1'b1, 3'd1, 1'b1}) begin
            n_errors++; $display("FAIL empty_rw_status got cnt=%0d udf=%b / cnt=%0d udf=%b exp 1/1", s_count, s_udf, f_count, f_udf);
        end
        n_checks++;
        if (f_rdata !== 8'h77 || s_rdata !== 8'h66) begin
            n_errors++; $display("FAIL empty_rw_data got fwft=%h std=%h exp 77/66", f_rdata, s_rdata);
        end
        step(0, 1, 0, 8'h00);
        n_checks++;
        if (s_rdata !== 8'h77 || s_empty !== 1'b1) begin
            n_errors++; $display("FAIL empty_rw_next got=%h empty=%b exp 77/1", s_rdata, s_empty);
        end
    endtask

    task automatic test_flush();
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'hC1 + i));
        step(0, 1, 0, 8'h00);
        n_checks++;
        if (s_count !== 3'd3 || s_ovf !== 1'b1 || s_rdata !== 8'hC1) begin
            n_errors++; $display("FAIL flush_pre got cnt=%0d ovf=%b data=%h exp 3/1/c1", s_count, s_ovf, s_rdata);
        end
        step(1, 0, 1, 8'hEE);
        n_checks++;
        if ({s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_udf} !== 9'b000_1_0_1_0_0_0) begin
            n_errors++; $display("FAIL flush_std_status got=%b exp=%b", {s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_udf}, 9'b000_1_0_1_0_0_0);
        end
        n_checks++;
        if ({f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_udf} !== 9'b000_1_0_1_0_0_0) begin
            n_errors++; $display("FAIL flush_fwft_status got=%b exp=%b", {f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_udf}, 9'b000_1_0_1_0_0_0);
        end
        n_checks++;
        if (s_rdata !== 8'hC1) begin
            n_errors++; $display("FAIL flush_rdata_hold got=%h exp=c1", s_rdata);
        end
        step(1, 0, 0, 8'h12);
        n_checks++;
        if (f_rdata !== 8'h12 || s_count !== 3'd1) begin
            n_errors++; $display("FAIL flush_discard got head=%h cnt=%0d exp 12/1", f_rdata, s_count);
        end
        step(0, 1, 0, 8'h00);
        n_checks++;
        if (s_rdata !== 8'h12) begin
            n_errors++; $display("FAIL flush_after_read got=%h exp=12", s_rdata);
        end
    endtask

    task automatic test_random();
        int r;
        bit r_wr, r_rd, r_clr;
        logic [8:0] es;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r     = $urandom_range(0, 99);
            r_clr = (r < 3);
            reset_n = (r == 99) ? 1'b0 : 1'b1;
            r_wr  = ($urandom_range(0, 99) < 55);
            r_rd  = ($urandom_range(0, 99) < 50);
            if (mq.size() > 0) begin
                n_checks++;
                if (f_rdata !== mq[0]) begin
                    n_errors++; $display("FAIL rnd_fwft_head cyc=%0d got=%h exp=%h", cyc, f_rdata, mq[0]);
                end
            end
            step(r_wr, r_rd, r_clr, 8'($urandom));
            reset_n = 1'b1;
            es = exp_status();
            n_checks++;
            if ({s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_udf} !== es) begin
                n_errors++; $display("FAIL rnd_std_status cyc=%0d got=%b exp=%b", cyc, {s_count, s_empty, s_full, s_ae, s_af, s_ovf, s_udf}, es);
            end
            n_checks++;
            if ({f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_udf} !== es) begin
                n_errors++; $display("FAIL rnd_fwft_status cyc=%0d got=%b exp=%b", cyc, {f_count, f_empty, f_full, f_ae, f_af, f_ovf, f_udf}, es);
            end
            n_checks++;
            if (s_rdata !== m_rs) begin
                n_errors++; $display("FAIL rnd_std_rdata cyc=%0d got=%h exp=%h", cyc, s_rdata, m_rs);
            end
        end
    endtask

    initial begin
        clk = 1'b0; reset_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
        m_ovf = 0; m_udf = 0; m_rs = 8'h00;
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simul_full();
        test_simul_empty();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fifo_level.md
# fifo_level

Parametrised synchronous FIFO with occupancy count, programmable almost-full/almost-empty thresholds, selectable read mode (registered or first-word-fall-through), sticky overflow/underflow error flags, and a synchronous flush. It replaces the basic FIFO wherever producers and consumers need flow-control lookahead, such as UART/PS2 buffering or video line staging. It sits in a single clock domain between a producer issuing `wr` strobes and a consumer issuing `rd` strobes.

## Interface
- `B`, 8, data word width in bits
- `W`, 4, address bits; depth `D = 2**W`
- `AF_TH`, `2**W-2`, almost_full asserts when count >= AF_TH; legal range 1..D
- `AE_TH`, 2, almost_empty asserts when count <= AE_TH; legal range 0..D-1
- `FWFT`, 0, read mode: 0 = registered read, 1 = first-word-fall-through
---
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `clr`  in  1  synchronous flush; empties FIFO and clears error flags
- `wr`  in  1  write strobe
- `w_data`  in  B  write data
- `rd`  in  1  read strobe
- `r_data`  out  B  read data
- `empty`, `full`  out  1 each  occupancy status
- `almost_empty`, `almost_full`  out  1 each  threshold status
- `count`  out  W+1  words stored, 0..D
- `overflow`, `underflow`  out  1 each  sticky error flags

## Operation
- Read acceptance: `rd_acc = rd & ~empty`.
- Write acceptance: `wr_acc = wr & (~full | rd)`. When full, a simultaneous read frees a slot, so the write is accepted.
- When empty with `rd & wr`: the write is accepted, the read is ignored, and `underflow` sets.
- Pointers are W bits and wrap modulo D.
- Count update: `count_next = count + wr_acc - rd_acc`.
- Status flags are decoded from the registered count:
  - `empty = (count==0)`
  - `full = (count==D)`
  - `almost_full = (count>=AF_TH)`
  - `almost_empty = (count<=AE_TH)`
- `overflow` sets on `wr & ~wr_acc`. `underflow` sets on `rd & ~rd_acc`. Both hold until `clr` or reset.
- Priority, highest first: `reset_n`=0, then `clr`, then normal rd/wr. During `clr`, rd/wr are ignored and storage is not written.
- Storage is read-before-write: a same-cycle write to the slot being read does not affect the returned word.
- FWFT=0: on `rd_acc`, `r_data` loads the head word at that edge. Otherwise `r_data` holds its value.
- FWFT=1: `r_data` shows the head word whenever `~empty`. Its value is don't-care while empty.

## Timing
- After any edge with `reset_n`=0:
  - `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0
  - `overflow`=0, `underflow`=0
  - `r_data`=0 in FWFT=0
  - Storage contents are not reset.
- Reset mid-operation discards all data. The behaviour of `clr` is identical, except that `r_data` holds its value.
- A write at edge N updates `count`/flags after N. In FWFT=1, the written word appears on `r_data` after N if the FIFO was empty.
- FWFT=0 read latency is 1 edge: `rd` at edge N gives data valid after N.
- FWFT=1 read latency is 0: data is valid before the `rd` edge, and `rd` advances to the next word.
- All outputs except FWFT=1 `r_data` come straight from registers.

## Structure
- A shared header holds the mode constants `FIFO_STD`=0 and `FIFO_FWFT`=1.
- Sub-module `reg_file`: B×D dual-port storage with a synchronous write port and an asynchronous read port. The FWFT=0 output register lives in the top level.
- The top level contains the pointer/count next-state logic and flag decoding in one always block.

## Test plan
All scenarios use B=8, W=2, AF_TH=3, AE_TH=1.
- **Reset:** hold `reset_n`=0 for 2 cycles, then release -> `count`=0, `empty`=1, `almost_empty`=1, all other flags 0, `r_data`=0.
- **Fill to full:** write 0x11, 0x22, 0x33, 0x44 -> `count` steps 1,2,3,4; `almost_empty` drops after count=2; `almost_full` at count=3; `full` at 4. A 5th write -> `count` stays 4 and `overflow`=1.
- **Drain order and wrap:** from full, read 4 times -> data 0x11..0x44 in order, then `empty`=1. Write 0x55, read again -> 0x55 (pointer wrap). FWFT=0 data lags `rd` by one edge; FWFT=1 data leads `rd`.
- **Simultaneous at full:** `rd`&`wr`(0x66) together -> `count` stays 4, `overflow` stays 0, read returns the oldest word, and 0x66 is read last.
- **Simultaneous at empty:** `rd`&`wr`(0x77) together -> `count`=1, `underflow`=1; the next read returns 0x77.
- **Flush:** with `count`=3 and `overflow`=1, assert `clr` together with `wr` -> after the edge `count`=0, `empty`=1, flags 0, and the write is discarded.
